// File: rtl/gru_seq_ctrl.sv
// Sequence controller for a serial GRU step engine: input FIFO, recurrent h_reg,
// start/done stepping and valid/ready output. Watchdog enabled by GRU_SEQ_TIMEOUT_EN.
module gru_seq_ctrl #(
    parameter int                    DATA_WIDTH     = 32,
    parameter int                    GRU_UNITS      = 3,
    parameter int                    INPUT_FEATURES = 3,
    parameter int                    FIFO_DEPTH     = 4,
    parameter int                    CNT_WIDTH      = 16,
    parameter logic [CNT_WIDTH-1:0]  TIMEOUT_CYCLES = 16'd10000
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 i_x_valid,
    output logic                                 o_x_ready,
    input  logic [INPUT_FEATURES*DATA_WIDTH-1:0] i_x_data,
    input  logic                                 i_x_last,
    input  logic                                 i_out_all,
    output logic                                 o_step_start,
    input  logic                                 i_step_done,
    output logic [INPUT_FEATURES*DATA_WIDTH-1:0] o_step_x,
    output logic [GRU_UNITS*DATA_WIDTH-1:0]      o_step_h_prev,
    input  logic [GRU_UNITS*DATA_WIDTH-1:0]      i_step_h_new,
    output logic                                 o_h_valid,
    input  logic                                 i_h_ready,
    output logic [GRU_UNITS*DATA_WIDTH-1:0]      o_h_data,
    output logic                                 o_h_last,
    output logic [CNT_WIDTH-1:0]                 o_step_idx,
    output logic                                 o_busy,
    output logic                                 o_err_timeout,
    input  logic                                 i_clr_err
);
    localparam int XW = INPUT_FEATURES * DATA_WIDTH;
    localparam int HW = GRU_UNITS * DATA_WIDTH;
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] DEPTH_C = (AW+1)'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_WAIT_DONE, S_WAIT_ACK, S_EMIT, S_ABORT, S_DRAIN
    } state_t;

    state_t              state_reg, state_next;
    logic [XW-1:0]       x_reg, x_next;
    logic                last_reg, last_next;
    logic [HW-1:0]       h_reg, h_next;
    logic                start_reg, start_next;
    logic                h_valid_reg, h_valid_next;
    logic [HW-1:0]       h_data_reg, h_data_next;
    logic                h_last_reg, h_last_next;
    logic [CNT_WIDTH-1:0] idx_reg, idx_next;

    // FIFO of {last, x}
    logic [XW:0]   fifo_mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_reg, rd_ptr_reg;
    logic [AW:0]   count_reg;
    logic [XW:0]   fifo_head;
    logic          fifo_full, fifo_empty, push, pop;

    assign fifo_full  = (count_reg == DEPTH_C);
    assign fifo_empty = (count_reg == '0);
    assign o_x_ready  = !fifo_full && !rst;
    assign push       = i_x_valid && o_x_ready;
    assign fifo_head  = fifo_mem[rd_ptr_reg];

    always_ff @(posedge clk) begin
        if (push)
            fifo_mem[wr_ptr_reg] <= {i_x_last, i_x_data};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
            case ({push, pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

`ifdef GRU_SEQ_TIMEOUT_EN
    logic [CNT_WIDTH-1:0] timer_reg, timer_next;
    logic                 err_reg, err_next;
    logic                 abort_set;
`else
    logic unused_cfg;
    assign unused_cfg = ^{i_clr_err, TIMEOUT_CYCLES};
`endif

    always_comb begin
        state_next   = state_reg;
        x_next       = x_reg;
        last_next    = last_reg;
        h_next       = h_reg;
        start_next   = start_reg;
        h_valid_next = h_valid_reg;
        h_data_next  = h_data_reg;
        h_last_next  = h_last_reg;
        idx_next     = idx_reg;
        pop          = 1'b0;
`ifdef GRU_SEQ_TIMEOUT_EN
        timer_next   = timer_reg;
        abort_set    = 1'b0;
`endif
        case (state_reg)
            S_IDLE: begin
                if (!fifo_empty) begin
                    pop        = 1'b1;
                    x_next     = fifo_head[XW-1:0];
                    last_next  = fifo_head[XW];
                    state_next = S_START;
                end
            end
            S_START: begin
                start_next = 1'b1;
`ifdef GRU_SEQ_TIMEOUT_EN
                timer_next = '0;
`endif
                state_next = S_WAIT_DONE;
            end
            S_WAIT_DONE: begin
`ifdef GRU_SEQ_TIMEOUT_EN
                timer_next = timer_reg + 1'b1;
`endif
                if (i_step_done) begin
                    h_next     = i_step_h_new;
                    start_next = 1'b0;
                    state_next = S_WAIT_ACK;
                end
`ifdef GRU_SEQ_TIMEOUT_EN
                else if (timer_reg == TIMEOUT_CYCLES - 1'b1) begin
                    start_next = 1'b0;
                    abort_set  = 1'b1;
                    h_next     = '0;
                    idx_next   = '0;
                    state_next = S_ABORT;
                end
`endif
            end
            S_WAIT_ACK: begin
                if (!i_step_done) begin
                    if (i_out_all || last_reg) begin
                        h_data_next  = h_reg;
                        h_last_next  = last_reg;
                        h_valid_next = 1'b1;
                        state_next   = S_EMIT;
                    end else begin
                        idx_next   = idx_reg + 1'b1;
                        state_next = S_IDLE;
                    end
                end
            end
            S_EMIT: begin
                if (i_h_ready) begin
                    h_valid_next = 1'b0;
                    if (h_last_reg) begin
                        h_next   = '0;
                        idx_next = '0;
                    end else begin
                        idx_next = idx_reg + 1'b1;
                    end
                    state_next = S_IDLE;
                end
            end
`ifdef GRU_SEQ_TIMEOUT_EN
            S_ABORT: begin
                // engine must release done before the next start
                if (!i_step_done)
                    state_next = last_reg ? S_IDLE : S_DRAIN;
            end
            S_DRAIN: begin
                if (!fifo_empty) begin
                    pop = 1'b1;
                    if (fifo_head[XW])
                        state_next = S_IDLE;
                end
            end
`endif
            default: state_next = S_IDLE;
        endcase
`ifdef GRU_SEQ_TIMEOUT_EN
        // a same-cycle timeout wins over the clear request
        err_next = err_reg;
        if (abort_set)
            err_next = 1'b1;
        else if (i_clr_err)
            err_next = 1'b0;
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= S_IDLE;
            x_reg       <= '0;
            last_reg    <= 1'b0;
            h_reg       <= '0;
            start_reg   <= 1'b0;
            h_valid_reg <= 1'b0;
            h_data_reg  <= '0;
            h_last_reg  <= 1'b0;
            idx_reg     <= '0;
`ifdef GRU_SEQ_TIMEOUT_EN
            timer_reg   <= '0;
            err_reg     <= 1'b0;
`endif
        end else begin
            state_reg   <= state_next;
            x_reg       <= x_next;
            last_reg    <= last_next;
            h_reg       <= h_next;
            start_reg   <= start_next;
            h_valid_reg <= h_valid_next;
            h_data_reg  <= h_data_next;
            h_last_reg  <= h_last_next;
            idx_reg     <= idx_next;
`ifdef GRU_SEQ_TIMEOUT_EN
            timer_reg   <= timer_next;
            err_reg     <= err_next;
`endif
        end
    end

`ifdef GRU_SEQ_TIMEOUT_EN
    assign o_err_timeout = err_reg;
`else
    assign o_err_timeout = 1'b0;
`endif
    assign o_step_start  = start_reg;
    assign o_step_x      = x_reg;
    assign o_step_h_prev = h_reg;
    assign o_h_valid     = h_valid_reg;
    assign o_h_data      = h_data_reg;
    assign o_h_last      = h_last_reg;
    assign o_step_idx    = idx_reg;
    assign o_busy        = (state_reg != S_IDLE);
endmodule

// File: tb/tb_gru_seq_ctrl.sv
// Directed bench for gru_seq_ctrl with an adder stub engine (h_new = h_prev + x, done 5 cycles after start).
module tb_gru_seq_ctrl;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        i_x_valid = 1'b0;
    logic        o_x_ready;
    logic [95:0] i_x_data = '0;
    logic        i_x_last = 1'b0;
    logic        i_out_all = 1'b0;
    logic        o_step_start;
    logic        i_step_done;
    logic [95:0] o_step_x;
    logic [95:0] o_step_h_prev;
    logic [95:0] i_step_h_new;
    logic        o_h_valid;
    logic        i_h_ready = 1'b0;
    logic [95:0] o_h_data;
    logic        o_h_last;
    logic [15:0] o_step_idx;
    logic        o_busy;
    logic        o_err_timeout;
    logic        i_clr_err = 1'b0;

    int checks = 0;
    int errors = 0;
    logic eng_hang = 1'b0;
    int   eng_cnt;

    gru_seq_ctrl #(
        .DATA_WIDTH(32), .GRU_UNITS(3), .INPUT_FEATURES(3), .FIFO_DEPTH(4),
        .CNT_WIDTH(16), .TIMEOUT_CYCLES(16'd16)
    ) dut (
        .clk(clk), .rst(rst),
        .i_x_valid(i_x_valid), .o_x_ready(o_x_ready), .i_x_data(i_x_data), .i_x_last(i_x_last),
        .i_out_all(i_out_all),
        .o_step_start(o_step_start), .i_step_done(i_step_done), .o_step_x(o_step_x),
        .o_step_h_prev(o_step_h_prev), .i_step_h_new(i_step_h_new),
        .o_h_valid(o_h_valid), .i_h_ready(i_h_ready), .o_h_data(o_h_data), .o_h_last(o_h_last),
        .o_step_idx(o_step_idx), .o_busy(o_busy), .o_err_timeout(o_err_timeout), .i_clr_err(i_clr_err)
    );

    always #5 clk = ~clk;

    // stub engine
    always @(posedge clk) begin
        if (rst) begin
            eng_cnt      <= 0;
            i_step_done  <= 1'b0;
            i_step_h_new <= '0;
        end else if (!o_step_start) begin
            eng_cnt     <= 0;
            i_step_done <= 1'b0;
        end else if (!i_step_done && !eng_hang) begin
            if (eng_cnt == 4) begin
                i_step_done <= 1'b1;
                for (int e = 0; e < 3; e++)
                    i_step_h_new[e*32 +: 32] <= o_step_h_prev[e*32 +: 32] + o_step_x[e*32 +: 32];
            end else begin
                eng_cnt <= eng_cnt + 1;
            end
        end
    end

    typedef struct {
        logic [31:0] x;
        logic        last;
        logic        out_all;
        logic        emit;
        logic [31:0] h;
        logic        h_last;
        logic [15:0] idx;
    } vec_t;

    vec_t tbl[8];

    task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // called at a negedge; returns at the negedge after the accepting edge
    task automatic push(input logic [31:0] x, input logic last);
        int t = 0;
        while (!o_x_ready && t < 200) begin
            @(negedge clk);
            t++;
        end
        check("push_ready", o_x_ready, 1'b1);
        i_x_valid = 1'b1;
        i_x_data  = {3{x}};
        i_x_last  = last;
        @(negedge clk);
        i_x_valid = 1'b0;
        $display("push x=%0d last=%0d", x, last);
    endtask

    task automatic wait_out(input logic [31:0] h, input logic l, input logic [15:0] idx, input string nm);
        int t = 0;
        while (!o_h_valid && t < 300) begin
            @(negedge clk);
            t++;
        end
        check({nm, "_valid"}, o_h_valid, 1'b1);
        if (!o_h_valid) return;
        $display("out h=%0d last=%0d idx=%0d", o_h_data[31:0], o_h_last, o_step_idx);
        check({nm, "_data"}, o_h_data, {3{h}});
        check({nm, "_last"}, o_h_last, l);
        check({nm, "_idx"}, o_step_idx, idx);
        i_h_ready = 1'b1;
        @(negedge clk);
        i_h_ready = 1'b0;
        check({nm, "_valid_drop"}, o_h_valid, 1'b0);
    endtask

    task automatic wait_noemit(input string nm);
        int t = 0;
        logic seen = 1'b0;
        while (!o_busy && t < 50) begin
            @(negedge clk);
            t++;
        end
        check({nm, "_busy"}, o_busy, 1'b1);
        t = 0;
        while (o_busy && t < 100) begin
            if (o_h_valid) seen = 1'b1;
            @(negedge clk);
            t++;
        end
        check({nm, "_idle"}, o_busy, 1'b0);
        check({nm, "_no_output"}, seen, 1'b0);
        $display("step done, no output");
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "bench timed out");
    end

    initial begin
        logic [95:0] held;
        logic        stable;
        int          n;
        logic [31:0] acc;

        tbl[0] = '{32'd1, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 16'd0};
        tbl[1] = '{32'd2, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 16'd0};
        tbl[2] = '{32'd3, 1'b1, 1'b0, 1'b1, 32'd6, 1'b1, 16'd2};
        tbl[3] = '{32'd1, 1'b0, 1'b1, 1'b1, 32'd1, 1'b0, 16'd0};
        tbl[4] = '{32'd2, 1'b0, 1'b1, 1'b1, 32'd3, 1'b0, 16'd1};
        tbl[5] = '{32'd3, 1'b1, 1'b1, 1'b1, 32'd6, 1'b1, 16'd2};
        tbl[6] = '{32'd4, 1'b1, 1'b0, 1'b1, 32'd4, 1'b1, 16'd0};
        tbl[7] = '{32'd5, 1'b1, 1'b0, 1'b1, 32'd5, 1'b1, 16'd0};

        repeat (3) @(negedge clk);
        check("rst_x_ready", o_x_ready, 1'b0);
        check("rst_start", o_step_start, 1'b0);
        check("rst_h_valid", o_h_valid, 1'b0);
        check("rst_busy", o_busy, 1'b0);
        check("rst_err", o_err_timeout, 1'b0);
        check("rst_idx", o_step_idx, 16'd0);
        check("rst_h_prev", o_step_h_prev, 96'd0);
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_ready", o_x_ready, 1'b1);

        for (int i = 0; i < 8; i++) begin
            i_out_all = tbl[i].out_all;
            push(tbl[i].x, tbl[i].last);
            if (tbl[i].emit)
                wait_out(tbl[i].h, tbl[i].h_last, tbl[i].idx, $sformatf("tbl%0d", i));
            else
                wait_noemit($sformatf("tbl%0d", i));
        end

        // backpressure: six vectors offered while the output is stalled
        i_out_all = 1'b1;
        fork
            begin
                for (int k = 1; k <= 6; k++) push(k, k == 6);
            end
        join_none
        n = 0;
        while (!o_h_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        held = o_h_data;
        stable = 1'b1;
        repeat (40) begin
            @(negedge clk);
            if (o_h_data !== held || !o_h_valid) stable = 1'b0;
        end
        check("bp_stable", stable, 1'b1);
        check("bp_data", held, {3{32'd1}});
        check("bp_x_ready_low", o_x_ready, 1'b0);
        acc = 0;
        for (int k = 1; k <= 6; k++) begin
            acc = acc + k;
            wait_out(acc, k == 6, 16'(k - 1), $sformatf("bp%0d", k));
        end
        i_out_all = 1'b0;

`ifdef GRU_SEQ_TIMEOUT_EN
        eng_hang = 1'b1;
        push(32'd1, 1'b0);
        fork
            begin
                push(32'd2, 1'b1);
                push(32'd7, 1'b1);
            end
        join_none
        n = 0;
        while (!o_step_start && n < 50) begin
            @(negedge clk);
            n++;
        end
        n = 0;
        while (o_step_start && n < 100) begin
            n++;
            @(negedge clk);
        end
        eng_hang = 1'b0;
        check("wd_start_cycles", 96'(n), 96'd16);
        check("wd_err_set", o_err_timeout, 1'b1);
        wait_out(32'd7, 1'b1, 16'd0, "wd_next");
        check("wd_err_sticky", o_err_timeout, 1'b1);
        i_clr_err = 1'b1;
        @(negedge clk);
        i_clr_err = 1'b0;
        check("wd_err_clr", o_err_timeout, 1'b0);
`else
        eng_hang = 1'b1;
        push(32'd1, 1'b1);
        repeat (30) @(negedge clk);
        check("nowd_start_held", o_step_start, 1'b1);
        check("nowd_err", o_err_timeout, 1'b0);
        eng_hang = 1'b0;
        wait_out(32'd1, 1'b1, 16'd0, "nowd_out");
`endif

        // reset in WAIT_DONE with a vector still buffered
        push(32'd3, 1'b1);
        push(32'd4, 1'b1);
        n = 0;
        while (!o_step_start && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("mid_start", o_step_start, 1'b1);
        rst = 1'b1;
        @(negedge clk);
        check("mid_rst_start", o_step_start, 1'b0);
        check("mid_rst_x", o_step_x, 96'd0);
        check("mid_rst_h_data", o_h_data, 96'd0);
        check("mid_rst_h_last", o_h_last, 1'b0);
        check("mid_rst_busy", o_busy, 1'b0);
        check("mid_rst_x_ready", o_x_ready, 1'b0);
        rst = 1'b0;
        @(negedge clk);
        check("mid_post_ready", o_x_ready, 1'b1);
        stable = 1'b1;
        repeat (5) begin
            @(negedge clk);
            if (o_busy) stable = 1'b0;
        end
        check("mid_fifo_flushed", stable, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
